alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the block SHALL support only WIDTH=32.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: req_valid  input  1  the requester offers an operation.
REQ-005 Port: req_ready  output  1  the block accepts an operation this cycle.
REQ-006 Port: req_op  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT; 6 and 7 illegal.
REQ-007 Port: req_a, req_b  input  32 each  operands.
REQ-008 Port: alu_data1, alu_data2  output  32 each  operands driven to the ALU, registered.
REQ-009 Port: alu_op  output  4  ALU operation code, registered: ADD 0010, SUB 0011, AND 0000, OR 0001, XOR 0100, SLT 0111.
REQ-010 Port: alu_result  input  32  ALU result; alu_zero, alu_lt, alu_gt  input  1 each  ALU flags.
REQ-011 Port: rsp_valid  output  1  a response is held; rsp_ready  input  1  the consumer takes the response.
REQ-012 Port: rsp_result  output  32  captured result; rsp_zero, rsp_lt, rsp_gt, rsp_err  output  1 each.
REQ-013 Port: op_count  output  16  number of completed responses.

Function
REQ-014 The FSM SHALL have four states: IDLE, DRIVE, CAPTURE, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-016 On acceptance, the block SHALL register req_a, req_b and the mapped alu_op, then go IDLE->DRIVE.
REQ-017 DRIVE SHALL last 1 cycle (ALU settling) and then go to CAPTURE.
REQ-018 In CAPTURE, the block SHALL latch alu_result and alu_zero into rsp_*, then go to RESP.
REQ-019 rsp_valid SHALL be asserted exactly 3 cycles after the acceptance edge.
REQ-020 rsp_lt and rsp_gt SHALL be computed from the registered operands as unsigned comparisons: lt=(a<b), gt=(a>b), both 0 when a==b.
REQ-021 The block SHALL ignore alu_lt and alu_gt, because the ALU holds their previous values when the operands are equal.
REQ-022 In RESP, rsp_valid SHALL be 1 and every rsp_* output SHALL be held stable until rsp_ready is 1.
REQ-023 When rsp_ready is 1 in RESP, the FSM SHALL go to IDLE and op_count SHALL increment; op_count SHALL wrap from 0xFFFF to 0.
REQ-024 No new request SHALL be accepted in the same cycle as a response handshake; back-to-back throughput is 1 operation per 4 cycles.
REQ-025 An illegal req_op (6 or 7) SHALL be executed as ADD and SHALL produce rsp_err=1; a legal op SHALL produce rsp_err=0.
REQ-026 req_* inputs outside an acceptance cycle SHALL have no effect; alu_data1, alu_data2 and alu_op SHALL stay constant from acceptance until the next acceptance.
REQ-027 A rsp_ready pulse outside RESP SHALL be ignored.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, req_ready=1 after release, alu_data1=alu_data2=0, alu_op=0010, rsp_valid=0, rsp_result=0, all rsp flags=0, op_count=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation, discard the pending response and leave op_count=0.

Structure
REQ-030 The req_op codes, the ALU 4-bit op codes and the FSM state encoding SHALL be defined in a shared package, alu_pkg, that the ALU control logic also uses.
REQ-031 The req_op-to-alu_op mapping SHALL be a combinational sub-module, alu_op_map, with outputs alu_op and err; the FSM, registers and counter SHALL stay in alu_sequencer.

Verification
REQ-032 ADD: a=1, b=2, op=0 -> alu_op=0010; 3 cycles later rsp_result=3, zero=0, lt=1, gt=0, err=0.
REQ-033 SUB equal: a=b=7, op=1 -> rsp_result=0, zero=1, lt=0, gt=0, even when the previous operation left the ALU lt flag at 1.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result stable and req_ready=0 throughout; on release, op_count increments by exactly 1.
REQ-035 Illegal op: op=6, a=0xFFFFFFFF, b=1 -> alu_op=0010, rsp_result=0, zero=1, gt=1, err=1.
REQ-036 Reset in DRIVE: rst_n pulsed low -> rsp_valid=0 immediately, alu_op=0010, op_count=0; the next request completes normally.
REQ-037 Wrap: preload op_count to 0xFFFF via 65535 operations (or force) and complete one more -> op_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: request op codes, ALU control codes
// and the sequencer FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        REQ_ADD = 3'd0,
        REQ_SUB = 3'd1,
        REQ_AND = 3'd2,
        REQ_OR  = 3'd3,
        REQ_XOR = 3'd4,
        REQ_SLT = 3'd5
    } req_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_map.sv
// Combinational translation of requester op codes into ALU control codes;
// unknown codes fall back to ADD and raise err.
module alu_op_map
    import alu_pkg::*;
(
    input  logic [2:0] req_op,
    output logic [3:0] alu_op,
    output logic       err
);

    // Op-code translation table
    always_comb begin
        alu_op = ALU_ADD;
        err    = 1'b0;
        case (req_op)
            REQ_ADD: alu_op = ALU_ADD;
            REQ_SUB: alu_op = ALU_SUB;
            REQ_AND: alu_op = ALU_AND;
            REQ_OR:  alu_op = ALU_OR;
            REQ_XOR: alu_op = ALU_XOR;
            REQ_SLT: alu_op = ALU_SLT;
            default: begin
                alu_op = ALU_ADD;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external ALU:
// accept -> drive operands -> capture result -> hold response until taken.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32  // only 32 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_lt,
    output logic             rsp_gt,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    state_e      state_r;
    state_e      next_state_s;
    logic [3:0]  map_op_s;
    logic        map_err_s;
    logic        err_pending_r;
    logic [15:0] op_count_r;
    logic        accept_s;
    logic        rsp_done_s;

    // alu_lt/alu_gt are stale when the operands are equal, so flags are
    // derived locally from the registered operands instead.
    logic        unused_flags_s;
    assign unused_flags_s = alu_lt ^ alu_gt;

    assign accept_s   = req_valid & req_ready;
    assign rsp_done_s = (state_r == ST_RESP) & rsp_ready;
    assign op_count   = op_count_r;

    alu_op_map u_op_map (
        .req_op (req_op),
        .alu_op (map_op_s),
        .err    (map_err_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_DRIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE:   next_state_s = ST_CAPTURE;
            ST_CAPTURE: next_state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // State register with registered handshake outputs decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            req_ready <= (next_state_s == ST_IDLE);
            rsp_valid <= (next_state_s == ST_RESP);
        end
    end

    // Operand and op-code registers, loaded only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data1     <= {WIDTH{1'b0}};
            alu_data2     <= {WIDTH{1'b0}};
            alu_op        <= ALU_ADD;
            err_pending_r <= 1'b0;
        end else if (accept_s) begin
            alu_data1     <= req_a;
            alu_data2     <= req_b;
            alu_op        <= map_op_s;
            err_pending_r <= map_err_s;
        end
    end

    // Response capture, held through RESP until the next capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= {WIDTH{1'b0}};
            rsp_zero   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state_r == ST_CAPTURE) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_lt     <= (alu_data1 < alu_data2);
            rsp_gt     <= (alu_data1 > alu_data2);
            rsp_err    <= err_pending_r;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'd0;
        end else if (rsp_done_s) begin
            op_count_r <= op_count_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, directed corner
// cases and randomized operations against a reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_data1, alu_data2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_lt = 1'b0;
    logic        alu_gt = 1'b0;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_lt, rsp_gt, rsp_err;
    logic [15:0] op_count;

    int          tests  = 0;
    int          errors = 0;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // External ALU model; its lt/gt flags hold their old value on equal operands
    always_comb begin
        case (alu_op)
            4'b0010: alu_result = alu_data1 + alu_data2;
            4'b0011: alu_result = alu_data1 - alu_data2;
            4'b0000: alu_result = alu_data1 & alu_data2;
            4'b0001: alu_result = alu_data1 | alu_data2;
            4'b0100: alu_result = alu_data1 ^ alu_data2;
            4'b0111: alu_result = {31'd0, ($signed(alu_data1) < $signed(alu_data2))};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    always @(posedge clk) begin
        if (alu_data1 != alu_data2) begin
            alu_lt <= (alu_data1 < alu_data2);
            alu_gt <= (alu_data1 > alu_data2);
        end
    end

    // Reference: result straight from the requester's op code
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu_op(input logic [2:0] op);
        logic [3:0] tbl [8];
        tbl = '{4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b0010, 4'b0010};
        return tbl[op];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, drive, capture, hold for 'hold' cycles, handshake
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int hold);
        logic [31:0] er;
        er = ref_result(op, a, b);
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = $urandom_range(0, 1); req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        rsp_ready = $urandom_range(0, 1);
        check("alu_op", {28'd0, alu_op}, {28'd0, ref_alu_op(op)});
        check("alu_data1", alu_data1, a);
        check("alu_data2", alu_data2, b);
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        check("valid_early", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rsp_ready = $urandom_range(0, 1);
        check("valid_early2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_result", rsp_result, er);
        check("rsp_flags", {28'd0, rsp_zero, rsp_lt, rsp_gt, rsp_err},
              {28'd0, (er == 32'd0), (a < b), (a > b), (op > 3'd5)});
        check("count_held", {16'd0, op_count}, {16'd0, exp_count});
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_result", rsp_result, er);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            check("bp_count", {16'd0, op_count}, {16'd0, exp_count});
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("done_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_ready", {31'd0, req_ready}, 32'd1);
        check("done_count", {16'd0, op_count}, {16'd0, exp_count});
        check("no_accept_on_hs", alu_data1, a);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
        exp_count = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_alu_op", {28'd0, alu_op}, 32'h2);
        check("rst_data", alu_data1 | alu_data2, 32'd0);
        check("rst_rsp", {rsp_result[0], rsp_valid, rsp_zero, rsp_lt, rsp_gt, rsp_err}, {27'd0, 5'd0} & 32'h3F);
        check("rst_result", rsp_result, 32'd0);
        check("rst_count", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        do_op(32'd1, 32'd2, 3'd0, 0);               // ADD, leaves ALU lt flag at 1
        do_op(32'd7, 32'd7, 3'd1, 0);               // SUB equal, stale lt must be ignored
        do_op(32'd5, 32'd9, 3'd4, 5);               // backpressure
        do_op(32'hFFFF_FFFF, 32'd1, 3'd6, 1);       // illegal op
        do_op(32'h1234_5678, 32'h0000_00FF, 3'd7, 0);

        // Reset during DRIVE
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd40; req_b = 32'd2;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_alu_op", {28'd0, alu_op}, 32'h2);
        check("mid_rst_count", {16'd0, op_count}, 32'd0);
        exp_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_op(32'd100, 32'd58, 3'd1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_op(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        // Counter wrap
        @(negedge clk);
        force dut.op_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_r;
        exp_count = 16'hFFFF;
        @(negedge clk);
        check("preload_count", {16'd0, op_count}, 32'h0000_FFFF);
        do_op(32'd3, 32'd3, 3'd2, 0);
        check("wrap_count", {16'd0, op_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
